// File: rtl/poco_dbus.sv
// Data-side bus unit: word RAM, GPIO and a 16-bit compare timer on the I/O page.
// Define POCO_DBUS_PRESCALE_EN to add the TPRE timer prescaler at I/O offset 5.
module poco_dbus #(
  parameter int         DATA_W  = 16,
  parameter int         RAM_AW  = 8,
  parameter logic [7:0] IO_PAGE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] ddataout,
  input  logic              we,
  output logic [DATA_W-1:0] ddatain,
  input  logic [15:0]       gpio_in,
  output logic [15:0]       gpio_out,
  output logic              irq
);

  localparam logic [7:0] OFF_GPO  = 8'd0;
  localparam logic [7:0] OFF_GPI  = 8'd1;
  localparam logic [7:0] OFF_TCNT = 8'd2;
  localparam logic [7:0] OFF_TCMP = 8'd3;
  localparam logic [7:0] OFF_TCTL = 8'd4;
  localparam logic [7:0] OFF_TPRE = 8'd5;

  typedef enum logic {T_IDLE, T_RUN} tstate_e;

  typedef struct packed {
    logic ie;
    logic pend;
    logic ar;
  } tctl_t;

  logic [DATA_W-1:0] mem_q [2**RAM_AW];

  logic              ram_hit, io_hit;
  logic [7:0]        io_off;
  logic              wr_gpo, wr_tcnt, wr_tcmp, wr_tctl, wr_tpre;

  logic [15:0]       gpio_out_q, gpio_out_d;
  logic [15:0]       sync1_q, sync2_q;
  logic [DATA_W-1:0] tcnt_q, tcnt_d;
  logic [DATA_W-1:0] tcmp_q, tcmp_d;
  tstate_e           state_q, state_d;
  tctl_t             ctl_q, ctl_d;
  logic              run, tick, match;

  assign ram_hit = (daddr >> RAM_AW) == '0;
  assign io_hit  = daddr[DATA_W-1:DATA_W-8] == IO_PAGE;
  assign io_off  = daddr[7:0];

  assign wr_gpo  = we && io_hit && io_off == OFF_GPO;
  assign wr_tcnt = we && io_hit && io_off == OFF_TCNT;
  assign wr_tcmp = we && io_hit && io_off == OFF_TCMP;
  assign wr_tctl = we && io_hit && io_off == OFF_TCTL;
  assign wr_tpre = we && io_hit && io_off == OFF_TPRE;

  assign run = state_q == T_RUN;

`ifdef POCO_DBUS_PRESCALE_EN
  logic [7:0] tpre_q, tpre_d;
  logic [7:0] pcnt_q, pcnt_d;

  assign tick = run && (pcnt_q == tpre_q);

  always_comb begin
    tpre_d = tpre_q;
    pcnt_d = pcnt_q + 8'd1;
    if (wr_tpre) tpre_d = ddataout[7:0];
    // Count only runs while enabled; a new TPRE restarts the division.
    if (!run || wr_tpre || tick) pcnt_d = 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tpre_q <= 8'd0;
      pcnt_q <= 8'd0;
    end else begin
      tpre_q <= tpre_d;
      pcnt_q <= pcnt_d;
    end
  end
`else
  assign tick = run;
`endif

  assign match = tick && (tcnt_q == tcmp_q);

  always_comb begin
    gpio_out_d = gpio_out_q;
    tcmp_d     = tcmp_q;
    tcnt_d     = tcnt_q;
    state_d    = state_q;
    ctl_d      = ctl_q;

    if (wr_gpo)  gpio_out_d = ddataout[15:0];
    if (wr_tcmp) tcmp_d     = ddataout;

    // CPU store to TCNT wins over both increment and match reload.
    if (wr_tcnt)           tcnt_d = ddataout;
    else if (match)        tcnt_d = ctl_q.ar ? '0 : tcnt_q;
    else if (tick)         tcnt_d = tcnt_q + 1'b1;

    if (match && !ctl_q.ar) state_d = T_IDLE;
    if (wr_tctl) begin
      state_d  = ddataout[0] ? T_RUN : T_IDLE;
      ctl_d.ar = ddataout[1];
      ctl_d.ie = ddataout[3];
      if (ddataout[2]) ctl_d.pend = 1'b0;
    end
    // A hardware match outranks a same-cycle write-1-clear.
    if (match) ctl_d.pend = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      tcnt_q     <= '0;
      tcmp_q     <= '1;
      state_q    <= T_IDLE;
      ctl_q      <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      tcnt_q     <= tcnt_d;
      tcmp_q     <= tcmp_d;
      state_q    <= state_d;
      ctl_q      <= ctl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && ram_hit) mem_q[daddr[RAM_AW-1:0]] <= ddataout;
  end

  always_comb begin
    ddatain = '0;
    if (ram_hit) begin
      ddatain = mem_q[daddr[RAM_AW-1:0]];
    end else if (io_hit) begin
      case (io_off)
        OFF_GPO:  ddatain = gpio_out_q;
        OFF_GPI:  ddatain = sync2_q;
        OFF_TCNT: ddatain = tcnt_q;
        OFF_TCMP: ddatain = tcmp_q;
        OFF_TCTL: ddatain = {{(DATA_W-4){1'b0}}, ctl_q.ie, ctl_q.pend, ctl_q.ar, run};
`ifdef POCO_DBUS_PRESCALE_EN
        OFF_TPRE: ddatain = {{(DATA_W-8){1'b0}}, tpre_q};
`endif
        default:  ddatain = '0;
      endcase
    end
  end

  assign gpio_out = gpio_out_q;
  assign irq      = ctl_q.pend & ctl_q.ie;

endmodule

// File: tb/tb_poco_dbus.sv
// Bench for poco_dbus: directed scenarios plus a randomized run against a
// transaction-level model of the RAM, GPIO and timer rules.
module tb_poco_dbus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] daddr = '0, ddataout = '0, ddatain;
  logic        we = 1'b0;
  logic [15:0] gpio_in = '0, gpio_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  poco_dbus dut (
    .clk(clk), .rst(rst), .daddr(daddr), .ddataout(ddataout), .we(we),
    .ddatain(ddatain), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_ram [256];
  bit          m_known [256];
  logic [15:0] m_gpo, m_s1, m_s2, m_tcnt, m_tcmp;
  bit          m_en, m_ar, m_pend, m_ie;
  logic [7:0]  m_tpre, m_pcnt;

  task automatic m_reset();
    m_gpo = 0; m_s1 = 0; m_s2 = 0; m_tcnt = 0; m_tcmp = 16'hFFFF;
    m_en = 0; m_ar = 0; m_pend = 0; m_ie = 0; m_tpre = 0; m_pcnt = 0;
  endtask

  function automatic logic [15:0] m_rd(input logic [15:0] a);
    if (a < 16'd256) return m_ram[a[7:0]];
    if (a[15:8] != 8'hFF) return 16'h0;
    case (a[7:0])
      8'd0: return m_gpo;
      8'd1: return m_s2;
      8'd2: return m_tcnt;
      8'd3: return m_tcmp;
      8'd4: return {12'h0, m_ie, m_pend, m_ar, m_en};
`ifdef POCO_DBUS_PRESCALE_EN
      8'd5: return {8'h0, m_tpre};
`endif
      default: return 16'h0;
    endcase
  endfunction

  // One clock edge of the specified behaviour: hardware effects first,
  // then CPU stores applied on top with the stated precedence rules.
  task automatic m_step(input logic [15:0] a, input logic [15:0] d, input logic w,
                        input logic [15:0] g);
    bit wr, tick, hit;
    wr = w && a[15:8] == 8'hFF;
`ifdef POCO_DBUS_PRESCALE_EN
    tick = m_en && (m_pcnt == m_tpre);
    if (!m_en || tick || (wr && a[7:0] == 8'd5)) m_pcnt = 0;
    else m_pcnt = m_pcnt + 1;
`else
    tick = m_en;
`endif
    hit = tick && (m_tcnt == m_tcmp);
    if (w && a < 16'd256) begin m_ram[a[7:0]] = d; m_known[a[7:0]] = 1; end
    m_s2 = m_s1; m_s1 = g;
    if (hit) begin
      m_pend = 1;
      if (m_ar) m_tcnt = 0; else m_en = 0;
    end else if (tick) m_tcnt = m_tcnt + 1;
    if (wr) case (a[7:0])
      8'd0: m_gpo = d;
      8'd2: m_tcnt = d;
      8'd3: m_tcmp = d;
      8'd4: begin
        m_en = d[0]; m_ar = d[1]; m_ie = d[3];
        if (d[2] && !hit) m_pend = 0;
      end
`ifdef POCO_DBUS_PRESCALE_EN
      8'd5: m_tpre = d[7:0];
`endif
      default: ;
    endcase
  endtask

  task automatic clk1();
    logic [15:0] a, d, g;
    logic w;
    a = daddr; d = ddataout; w = we; g = gpio_in;
    @(posedge clk);
    m_step(a, d, w, g);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    daddr = a; ddataout = d; we = 1'b1;
    clk1();
    we = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] v);
    daddr = a; we = 1'b0;
    #1;
    v = ddatain;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    logic [15:0] v;
    logic [15:0] addrs [5] = '{16'hFF00, 16'hFF01, 16'hFF02, 16'hFF03, 16'hFF04};
    logic [15:0] exps  [5] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      peek(addrs[i], v);
      checks++;
      if (v !== exps[i]) begin
        errors++;
        $display("FAIL reset_reg addr=%h got=%h exp=%h", addrs[i], v, exps[i]);
      end
    end
    checks++;
    if (gpio_out !== 16'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs gpio_out=%h irq=%b exp 0000/0", gpio_out, irq);
    end
  endtask

  task automatic test_ram();
    logic [15:0] v;
    wr(16'h0012, 16'hA5C3);
    peek(16'h0012, v);
    checks++;
    if (v !== 16'hA5C3) begin errors++; $display("FAIL ram_rd got=%h exp=a5c3", v); end
    wr(16'h0400, 16'h5555);
    peek(16'h0400, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL unmapped_rd got=%h exp=0000", v); end
    for (int i = 0; i < 24; i++) wr(16'($urandom_range(0, 31)), 16'($urandom));
    for (int a = 0; a < 32; a++) begin
      if (m_known[a]) begin
        peek(16'(a), v);
        checks++;
        if (v !== m_ram[a]) begin
          errors++;
          $display("FAIL ram_rand addr=%0d got=%h exp=%h", a, v, m_ram[a]);
        end
      end
      if (a % 4 == 3) clk1();
    end
  endtask

  task automatic test_gpio();
    logic [15:0] v;
    wr(16'hFF00, 16'h1234);
    checks++;
    if (gpio_out !== 16'h1234) begin errors++; $display("FAIL gpio_out got=%h exp=1234", gpio_out); end
    gpio_in = 16'h00FF;
    clk1();
    peek(16'hFF01, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL gpio_in_1edge got=%h exp=0000", v); end
    clk1();
    peek(16'hFF01, v);
    checks++;
    if (v !== 16'h00FF) begin errors++; $display("FAIL gpio_in_2edge got=%h exp=00ff", v); end
  endtask

  task automatic test_oneshot();
    logic [15:0] v;
    logic [15:0] seq [5] = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
    do_reset();
    wr(16'hFF03, 16'd3);
    wr(16'hFF04, 16'h0009);
    for (int i = 0; i < 5; i++) begin
      clk1();
      peek(16'hFF02, v);
      checks++;
      if (v !== seq[i]) begin errors++; $display("FAIL oneshot_tcnt step=%0d got=%h exp=%h", i, v, seq[i]); end
      if (i == 3) begin
        peek(16'hFF04, v);
        checks++;
        if (v !== 16'h000C || irq !== 1'b1) begin
          errors++;
          $display("FAIL oneshot_pend tctrl=%h irq=%b exp 000c/1", v, irq);
        end
      end
    end
    wr(16'hFF04, 16'h0004);
    peek(16'hFF04, v);
    checks++;
    if (v !== 16'h0000 || irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_clear tctrl=%h irq=%b exp 0000/0", v, irq);
    end
  endtask

  task automatic test_autoreload();
    logic [15:0] v;
    logic [15:0] seq [5] = '{16'd1, 16'd2, 16'd0, 16'd1, 16'd2};
    do_reset();
    wr(16'hFF03, 16'd2);
    wr(16'hFF04, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      clk1();
      peek(16'hFF02, v);
      checks++;
      if (v !== seq[i]) begin errors++; $display("FAIL ar_tcnt step=%0d got=%h exp=%h", i, v, seq[i]); end
      if (i == 2) begin
        peek(16'hFF04, v);
        checks++;
        if (v !== 16'h0007) begin errors++; $display("FAIL ar_pend got=%h exp=0007", v); end
      end
    end
    // clear attempted on the second match edge
    wr(16'hFF04, 16'h0007);
    peek(16'hFF04, v);
    checks++;
    if (v !== 16'h0007) begin errors++; $display("FAIL ar_clear_race got=%h exp=0007", v); end
    peek(16'hFF02, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL ar_reload got=%h exp=0000", v); end
    wr(16'hFF04, 16'h0007);
    peek(16'hFF04, v);
    checks++;
    if (v !== 16'h0003) begin errors++; $display("FAIL ar_clear got=%h exp=0003", v); end
  endtask

  task automatic test_collision();
    logic [15:0] v;
    do_reset();
    wr(16'hFF03, 16'd5);
    wr(16'hFF04, 16'h0001);
    repeat (5) clk1();
    wr(16'hFF02, 16'h0100);
    peek(16'hFF02, v);
    checks++;
    if (v !== 16'h0100) begin errors++; $display("FAIL coll_tcnt got=%h exp=0100", v); end
    peek(16'hFF04, v);
    checks++;
    if (v !== 16'h0004) begin errors++; $display("FAIL coll_pend got=%h exp=0004", v); end
    wr(16'hFF03, 16'hFFFF);
    wr(16'hFF02, 16'h0000);
    wr(16'hFF04, 16'h0001);
    repeat (4) clk1();
    rst = 1'b1;
    peek(16'hFF02, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL rst_tcnt got=%h exp=0000", v); end
    peek(16'hFF04, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL rst_tctrl got=%h exp=0000", v); end
    peek(16'hFF03, v);
    checks++;
    if (v !== 16'hFFFF) begin errors++; $display("FAIL rst_tcmp got=%h exp=ffff", v); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_prescale();
    logic [15:0] v;
    do_reset();
`ifdef POCO_DBUS_PRESCALE_EN
    begin
      logic [15:0] seq [6] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
      wr(16'hFF05, 16'd2);
      wr(16'hFF03, 16'd1);
      wr(16'hFF04, 16'h0001);
      for (int i = 0; i < 6; i++) begin
        clk1();
        peek(16'hFF02, v);
        checks++;
        if (v !== seq[i]) begin errors++; $display("FAIL pre_tcnt step=%0d got=%h exp=%h", i, v, seq[i]); end
      end
      peek(16'hFF04, v);
      checks++;
      if (v !== 16'h0004) begin errors++; $display("FAIL pre_pend got=%h exp=0004", v); end
      peek(16'hFF05, v);
      checks++;
      if (v !== 16'h0002) begin errors++; $display("FAIL pre_tpre got=%h exp=0002", v); end
    end
`else
    wr(16'hFF05, 16'd2);
    peek(16'hFF05, v);
    checks++;
    if (v !== 16'h0000) begin errors++; $display("FAIL tpre_absent got=%h exp=0000", v); end
`endif
  endtask

  task automatic test_random();
    logic [15:0] a, d, v, e;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: a = 16'($urandom_range(0, 15));
        3:       a = 16'h0400 | 16'($urandom_range(0, 255));
        default: a = 16'hFF00 | 16'($urandom_range(0, 7));
      endcase
      d = 16'($urandom);
      if (a == 16'hFF02 || a == 16'hFF03) d = d & 16'h000F;
      if (a == 16'hFF04) d = d & 16'h000F;
      if (a == 16'hFF05) d = d & 16'h0003;
      gpio_in = 16'($urandom);
      peek(a, v);
      e = m_rd(a);
      if (a >= 16'd256 || m_known[a[7:0]]) begin
        checks++;
        if (v !== e) begin errors++; $display("FAIL rand_rd n=%0d addr=%h got=%h exp=%h", n, a, v, e); end
      end
      ddataout = d; we = 1'($urandom_range(0, 1));
      clk1();
      we = 1'b0;
      checks++;
      if (gpio_out !== m_gpo || irq !== (m_pend & m_ie)) begin
        errors++;
        $display("FAIL rand_out n=%0d gpio_out=%h exp=%h irq=%b exp=%b", n, gpio_out, m_gpo, irq, m_pend & m_ie);
      end
    end
  endtask

  initial begin
    m_reset();
    for (int i = 0; i < 256; i++) begin m_ram[i] = '0; m_known[i] = 0; end
    #2;
    test_reset();
    test_ram();
    test_gpio();
    test_oneshot();
    test_autoreload();
    test_collision();
    test_prescale();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
